// File: rtl/pipelined_compressed_adder.sv
// pipelined_compressed_adder
//   Streaming K-bit add/subtract, split into L = K/SEG registered carry
//   segments so that each cycle only resolves a SEG-bit carry chain.
//   Full throughput with valid/ready backpressure on both sides.
//
// Parameters:
//   K    operand/result width (even, >= 4)
//   SEG  bits resolved per stage (even, divides K, 2 <= SEG <= K)
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid / in_ready  operand beat handshake
//   a, b, cin, sub       operands; sub=0: a+b+cin, sub=1: a-b-cin
//   out_valid/out_ready  result beat handshake
//   sum, cout, ovf       result mod 2^K, raw MSB carry, signed overflow
module pipelined_compressed_adder #(
  parameter int unsigned K   = 16,
  parameter int unsigned SEG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned L = K / SEG;

  // Effective operands: subtraction is a + ~b + ~cin.
  logic [K-1:0] bx_in;
  logic         c0;

  assign bx_in = sub ? ~b : b;
  assign c0    = sub ? ~cin : cin;

  // Per-stage state. Full-width words are kept per stage for uniform
  // indexing; bits a stage never reads are trimmed by synthesis.
  logic [L-1:0] v;
  logic [L-1:0] c_r;
  logic [K-1:0] a_r   [L];
  logic [K-1:0] bx_r  [L];
  logic [K-1:0] sum_r [L];

  logic [L:0]   rdy;
  logic [L-1:0] v_src;
  logic [L-1:0] c_src;
  logic [L-1:0] c_nx;
  logic [K-1:0] a_src   [L];
  logic [K-1:0] bx_src  [L];
  logic [K-1:0] sum_src [L];
  logic [K-1:0] sum_nx  [L];

  // SEG-bit adder built from 2-bit groups: within a pair the low bit's
  // carry feeds the high sum bit, and the pair's group generate/propagate
  // forms the carry into the next pair.
  function automatic logic [SEG:0] seg_add(
    input logic [SEG-1:0] x,
    input logic [SEG-1:0] y,
    input logic           ci
  );
    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG-1:0] s;
    logic           c;
    logic           c_mid;
    g = x & y;
    p = x ^ y;
    s = '0;
    c = ci;
    for (int unsigned j = 0; j < SEG / 2; j++) begin
      s[2*j]   = p[2*j] ^ c;
      c_mid    = g[2*j] | (p[2*j] & c);
      s[2*j+1] = p[2*j+1] ^ c_mid;
      c        = (g[2*j+1] | (p[2*j+1] & g[2*j])) | (p[2*j+1] & p[2*j] & c);
    end
    return {c, s};
  endfunction

  // Ready chain from the output back to the input: an empty stage always
  // accepts, so bubbles collapse even while the output is stalled.
  always_comb begin
    rdy    = '0;
    rdy[L] = out_ready;
    for (int unsigned i = 0; i < L; i++) begin
      rdy[L-1-i] = !v[L-1-i] || rdy[L-i];
    end
  end

  // Stage inputs: stage 0 takes the pins, later stages the previous stage.
  always_comb begin
    v_src[0]   = in_valid;
    c_src[0]   = c0;
    a_src[0]   = a;
    bx_src[0]  = bx_in;
    sum_src[0] = '0;
    for (int unsigned s = 1; s < L; s++) begin
      v_src[s]   = v[s-1];
      c_src[s]   = c_r[s-1];
      a_src[s]   = a_r[s-1];
      bx_src[s]  = bx_r[s-1];
      sum_src[s] = sum_r[s-1];
    end
  end

  // Each stage resolves its own slice and passes lower results through.
  always_comb begin
    for (int unsigned s = 0; s < L; s++) begin
      sum_nx[s] = sum_src[s];
      {c_nx[s], sum_nx[s][s*SEG +: SEG]} =
        seg_add(a_src[s][s*SEG +: SEG], bx_src[s][s*SEG +: SEG], c_src[s]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v   <= '0;
      c_r <= '0;
      for (int unsigned s = 0; s < L; s++) begin
        a_r[s]   <= '0;
        bx_r[s]  <= '0;
        sum_r[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < L; s++) begin
        if (rdy[s]) begin
          v[s] <= v_src[s];
          if (v_src[s]) begin
            a_r[s]   <= a_src[s];
            bx_r[s]  <= bx_src[s];
            sum_r[s] <= sum_nx[s];
            c_r[s]   <= c_nx[s];
          end
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[L-1];
  assign sum       = sum_r[L-1];
  assign cout      = c_r[L-1];
  // Operand sign bits travel with the beat so overflow needs only the
  // final stage's registers.
  assign ovf       = (a_r[L-1][K-1] == bx_r[L-1][K-1]) &&
                     (sum_r[L-1][K-1] != a_r[L-1][K-1]);

endmodule

// File: tb/tb_pipelined_compressed_adder.sv
// Testbench for pipelined_compressed_adder: directed vectors on the
// default K=16/SEG=4 build plus random streams on K=8/SEG=2 and
// K=32/SEG=32 builds.
module tb_pipelined_compressed_adder;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  logic        k8_in_valid, k8_in_ready, k8_cin, k8_sub, k8_out_valid, k8_out_ready, k8_cout, k8_ovf;
  logic [7:0]  k8_a, k8_b, k8_sum;

  logic        k32_in_valid, k32_in_ready, k32_cin, k32_sub, k32_out_valid, k32_out_ready, k32_cout, k32_ovf;
  logic [31:0] k32_a, k32_b, k32_sum;

  int n_cmp = 0;
  int n_bad = 0;

  pipelined_compressed_adder #(.K(16), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_compressed_adder #(.K(8), .SEG(2)) dut_k8 (
    .clk(clk), .rst_n(rst_n), .in_valid(k8_in_valid), .in_ready(k8_in_ready),
    .a(k8_a), .b(k8_b), .cin(k8_cin), .sub(k8_sub), .out_valid(k8_out_valid),
    .out_ready(k8_out_ready), .sum(k8_sum), .cout(k8_cout), .ovf(k8_ovf)
  );

  pipelined_compressed_adder #(.K(32), .SEG(32)) dut_k32 (
    .clk(clk), .rst_n(rst_n), .in_valid(k32_in_valid), .in_ready(k32_in_ready),
    .a(k32_a), .b(k32_b), .cin(k32_cin), .sub(k32_sub), .out_valid(k32_out_valid),
    .out_ready(k32_out_ready), .sum(k32_sum), .cout(k32_cout), .ovf(k32_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on a wide accumulator; returns {ovf,cout,sum}.
  function automatic logic [33:0] model(input int unsigned w, input logic [31:0] x,
                                        input logic [31:0] y, input logic ci, input logic sb);
    logic [63:0] mask, bxv, t;
    logic [31:0] s;
    logic        co, ov, c0;
    mask = (64'd1 << w) - 64'd1;
    bxv  = sb ? ((~{32'h0, y}) & mask) : {32'h0, y};
    c0   = sb ? ~ci : ci;
    t    = {32'h0, x} + bxv + {63'h0, c0};
    s    = t[31:0] & mask[31:0];
    co   = t[w];
    ov   = (x[w-1] == bxv[w-1]) && (s[w-1] != x[w-1]);
    return {ov, co, s};
  endfunction

  // Sends one beat into an empty main pipe and waits (bounded) for its
  // result; lat counts edges from acceptance to out_valid.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic ci,
                       input logic sb, output int lat, output logic [15:0] s,
                       output logic co, output logic ov);
    a = x; b = y; cin = ci; sub = sb;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    s  = sum;
    co = cout;
    ov = ovf;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (sum !== 16'h0000) begin n_bad++; $display("FAIL reset_sum: got %h expected 0000", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout: got %b expected 0", cout); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (k8_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_k8_out_valid: got %b expected 0", k8_out_valid); end
    n_cmp++; if (k32_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_k32_out_valid: got %b expected 0", k32_out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat; logic [15:0] s; logic co, ov;
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, lat, s, co, ov);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    n_cmp++; if (s !== 16'h5555) begin n_bad++; $display("FAIL basic_sum: got %h expected 5555", s); end
    n_cmp++; if (co !== 1'b0) begin n_bad++; $display("FAIL basic_cout: got %b expected 0", co); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b expected 0", ov); end
  endtask

  task automatic test_carry_ripple();
    int lat; logic [15:0] s; logic co, ov;
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, s, co, ov);
    n_cmp++; if (s !== 16'h0000) begin n_bad++; $display("FAIL wrap_sum: got %h expected 0000", s); end
    n_cmp++; if (co !== 1'b1) begin n_bad++; $display("FAIL wrap_cout: got %b expected 1", co); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL wrap_ovf: got %b expected 0", ov); end
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, s, co, ov);
    n_cmp++; if (s !== 16'h8000) begin n_bad++; $display("FAIL posovf_sum: got %h expected 8000", s); end
    n_cmp++; if (co !== 1'b0) begin n_bad++; $display("FAIL posovf_cout: got %b expected 0", co); end
    n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL posovf_ovf: got %b expected 1", ov); end
  endtask

  task automatic test_subtract();
    int lat; logic [15:0] s; logic co, ov;
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, lat, s, co, ov);
    n_cmp++; if (s !== 16'hFFFD) begin n_bad++; $display("FAIL sub_borrow_sum: got %h expected fffd", s); end
    n_cmp++; if (co !== 1'b0) begin n_bad++; $display("FAIL sub_borrow_cout: got %b expected 0", co); end
    n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL sub_borrow_ovf: got %b expected 0", ov); end
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, lat, s, co, ov);
    n_cmp++; if (s !== 16'h7FFF) begin n_bad++; $display("FAIL sub_ovf_sum: got %h expected 7fff", s); end
    n_cmp++; if (co !== 1'b1) begin n_bad++; $display("FAIL sub_ovf_cout: got %b expected 1", co); end
    n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL sub_ovf_ovf: got %b expected 1", ov); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [20];
    logic [15:0] vb [20];
    logic        vc [20];
    logic        vs [20];
    logic [33:0] q [$];
    logic [33:0] e;
    logic [17:0] hold_val;
    logic        held, saw_full, exp_rdy;
    int          sent, got, cyc;
    for (int i = 0; i < 20; i++) begin
      va[i] = 16'($urandom); vb[i] = 16'($urandom);
      vc[i] = 1'($urandom);  vs[i] = 1'($urandom);
    end
    sent = 0; got = 0; cyc = 0; held = 1'b0; saw_full = 1'b0; hold_val = '0;
    while (got < 20 && cyc < 200) begin
      out_ready = !(cyc >= 8 && cyc < 14);
      in_valid  = (sent < 20);
      if (sent < 20) begin
        a = va[sent]; b = vb[sent]; cin = vc[sent]; sub = vs[sent];
      end
      #1;
      exp_rdy = !(q.size() == 4 && !out_ready);
      n_cmp++; if (in_ready !== exp_rdy) begin n_bad++; $display("FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_rdy); end
      if (!exp_rdy) saw_full = 1'b1;
      if (held) begin
        n_cmp++;
        if (out_valid !== 1'b1 || {ovf, cout, sum} !== hold_val) begin
          n_bad++; $display("FAIL b2b_stall_hold cyc %0d: got v=%b %h expected v=1 %h", cyc, out_valid, {ovf, cout, sum}, hold_val);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++; $display("FAIL b2b_extra_beat cyc %0d: got result %h expected none", cyc, sum);
        end else begin
          e = q.pop_front();
          if ({ovf, cout, sum} !== {e[33], e[32], e[15:0]}) begin
            n_bad++; $display("FAIL b2b_result %0d: got %h expected %h", got, {ovf, cout, sum}, {e[33], e[32], e[15:0]});
          end
        end
        got++;
      end
      held     = out_valid && !out_ready;
      hold_val = {ovf, cout, sum};
      if (in_valid && exp_rdy) begin
        q.push_back(model(16, {16'h0, a}, {16'h0, b}, cin, sub));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (got !== 20) begin n_bad++; $display("FAIL b2b_count: got %0d expected 20", got); end
    n_cmp++; if (saw_full !== 1'b1) begin n_bad++; $display("FAIL b2b_full_seen: got %b expected 1", saw_full); end
  endtask

  task automatic test_async_reset();
    int lat; logic [15:0] s; logic co, ov; logic stale;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 16'h1111; b = 16'h2222; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL areset_pre_valid: got %b expected 1", out_valid); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL areset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (sum !== 16'h0000) begin n_bad++; $display("FAIL areset_sum: got %h expected 0000", sum); end
    n_cmp++; if (cout !== 1'b0 || ovf !== 1'b0) begin n_bad++; $display("FAIL areset_flags: got cout=%b ovf=%b expected 0 0", cout, ovf); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL areset_in_ready: got %b expected 1", in_ready); end
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) stale = 1'b1;
    end
    n_cmp++; if (stale !== 1'b0) begin n_bad++; $display("FAIL areset_stale_beat: got %b expected 0", stale); end
    issue(16'h0F0F, 16'h00F1, 1'b1, 1'b0, lat, s, co, ov);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL areset_next_latency: got %0d expected 4", lat); end
    n_cmp++; if ({ov, co, s} !== {1'b0, 1'b0, 16'h1001}) begin n_bad++; $display("FAIL areset_next_result: got %h expected %h", {ov, co, s}, {1'b0, 1'b0, 16'h1001}); end
  endtask

  task automatic test_reparam();
    int          lat8, lat32, sent8, got8, sent32, got32, cyc;
    logic [9:0]  r8;
    logic [33:0] r32, e;
    logic [33:0] q8 [$];
    logic [33:0] q32 [$];
    logic        er8, er32;
    // Directed latency/result beat on each build.
    k8_a = 8'hF0; k8_b = 8'h0F; k8_cin = 1'b1; k8_sub = 1'b0;
    k32_a = 32'h7FFF_FFFF; k32_b = 32'h0000_0001; k32_cin = 1'b0; k32_sub = 1'b0;
    k8_in_valid = 1'b1; k32_in_valid = 1'b1; k8_out_ready = 1'b1; k32_out_ready = 1'b1;
    tick();
    k8_in_valid = 1'b0; k32_in_valid = 1'b0;
    lat8 = 0; lat32 = 0; r8 = '0; r32 = '0;
    for (int c = 1; c <= 20; c++) begin
      if (k8_out_valid && lat8 == 0) begin lat8 = c; r8 = {k8_ovf, k8_cout, k8_sum}; end
      if (k32_out_valid && lat32 == 0) begin lat32 = c; r32 = {k32_ovf, k32_cout, k32_sum}; end
      tick();
    end
    n_cmp++; if (lat8 !== 4) begin n_bad++; $display("FAIL k8_latency: got %0d expected 4", lat8); end
    n_cmp++; if (lat32 !== 1) begin n_bad++; $display("FAIL k32_latency: got %0d expected 1", lat32); end
    n_cmp++; if (r8 !== {1'b0, 1'b1, 8'h00}) begin n_bad++; $display("FAIL k8_directed: got %h expected %h", r8, {1'b0, 1'b1, 8'h00}); end
    n_cmp++; if (r32 !== {1'b1, 1'b0, 32'h8000_0000}) begin n_bad++; $display("FAIL k32_directed: got %h expected %h", r32, {1'b1, 1'b0, 32'h8000_0000}); end

    // Random streams with random valid/ready on both builds at once.
    sent8 = 0; got8 = 0; sent32 = 0; got32 = 0; cyc = 0;
    while (cyc < 20000 && (got8 < 1000 || got32 < 1000)) begin
      k8_in_valid   = (sent8 < 1000) && ($urandom_range(0, 3) != 0);
      k8_out_ready  = ($urandom_range(0, 3) != 0);
      k8_a = 8'($urandom); k8_b = 8'($urandom); k8_cin = 1'($urandom); k8_sub = 1'($urandom);
      k32_in_valid  = (sent32 < 1000) && ($urandom_range(0, 3) != 0);
      k32_out_ready = ($urandom_range(0, 3) != 0);
      k32_a = $urandom; k32_b = $urandom; k32_cin = 1'($urandom); k32_sub = 1'($urandom);
      #1;
      er8  = !(q8.size() == 4 && !k8_out_ready);
      er32 = !(q32.size() == 1 && !k32_out_ready);
      n_cmp++; if (k8_in_ready !== er8) begin n_bad++; $display("FAIL k8_in_ready cyc %0d: got %b expected %b", cyc, k8_in_ready, er8); end
      n_cmp++; if (k32_in_ready !== er32) begin n_bad++; $display("FAIL k32_in_ready cyc %0d: got %b expected %b", cyc, k32_in_ready, er32); end
      if (k8_out_valid && k8_out_ready) begin
        n_cmp++;
        if (q8.size() == 0) begin
          n_bad++; $display("FAIL k8_extra_beat cyc %0d: got %h expected none", cyc, k8_sum);
        end else begin
          e = q8.pop_front();
          if ({k8_ovf, k8_cout, k8_sum} !== {e[33], e[32], e[7:0]}) begin
            n_bad++; $display("FAIL k8_result %0d: got %h expected %h", got8, {k8_ovf, k8_cout, k8_sum}, {e[33], e[32], e[7:0]});
          end
        end
        got8++;
      end
      if (k32_out_valid && k32_out_ready) begin
        n_cmp++;
        if (q32.size() == 0) begin
          n_bad++; $display("FAIL k32_extra_beat cyc %0d: got %h expected none", cyc, k32_sum);
        end else begin
          e = q32.pop_front();
          if ({k32_ovf, k32_cout, k32_sum} !== e) begin
            n_bad++; $display("FAIL k32_result %0d: got %h expected %h", got32, {k32_ovf, k32_cout, k32_sum}, e);
          end
        end
        got32++;
      end
      if (k8_in_valid && er8) begin
        q8.push_back(model(8, {24'h0, k8_a}, {24'h0, k8_b}, k8_cin, k8_sub));
        sent8++;
      end
      if (k32_in_valid && er32) begin
        q32.push_back(model(32, k32_a, k32_b, k32_cin, k32_sub));
        sent32++;
      end
      tick();
      cyc++;
    end
    k8_in_valid = 1'b0; k32_in_valid = 1'b0;
    n_cmp++; if (got8 !== 1000) begin n_bad++; $display("FAIL k8_count: got %0d expected 1000", got8); end
    n_cmp++; if (got32 !== 1000) begin n_bad++; $display("FAIL k32_count: got %0d expected 1000", got32); end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    k8_in_valid = 1'b0; k8_out_ready = 1'b0; k8_a = '0; k8_b = '0; k8_cin = 1'b0; k8_sub = 1'b0;
    k32_in_valid = 1'b0; k32_out_ready = 1'b0; k32_a = '0; k32_b = '0; k32_cin = 1'b0; k32_sub = 1'b0;
    test_reset();
    test_basic();
    test_carry_ripple();
    test_subtract();
    test_back_to_back();
    test_async_reset();
    test_reparam();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
